// File: rtl/sr_latch_exerciser.sv
// sr_latch_exerciser: drives a gated SR latch through SET/DIS/RESET/HOLD/INVALID and checks its outputs.
// Define SR_INVALID_CHECK_EN to also check (Q,Qn)=(0,0) during the INVALID phase.
module sr_latch_exerciser #(
    parameter int HOLD_CYCLES = 8,
    parameter int SETTLE = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       q_in,
    input  logic       qn_in,
    output logic       s_out,
    output logic       r_out,
    output logic       en_out,
    output logic [2:0] phase,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SET     = 3'd1,
        DIS     = 3'd2,
        RESET   = 3'd3,
        HOLD    = 3'd4,
        INVALID = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_cnt, w_cnt_nxt, w_err_nxt;
    logic       r_q_s1, r_q_s2, r_qn_s1, r_qn_s2;
    logic       w_last, w_chk_st, w_chk, w_mis, w_exp_q, w_exp_qn;

    assign w_last   = r_cnt == 8'(HOLD_CYCLES - 1);
    assign w_exp_q  = r_state == SET || r_state == DIS;
    assign w_exp_qn = r_state == RESET || r_state == HOLD;
`ifdef SR_INVALID_CHECK_EN
    assign w_chk_st = r_state inside {[SET:INVALID]};
`else
    assign w_chk_st = r_state inside {[SET:HOLD]};
`endif
    assign w_chk = w_chk_st && r_cnt == 8'(SETTLE);
    assign w_mis = w_chk && (r_q_s2 != w_exp_q || r_qn_s2 != w_exp_qn);
    assign w_err_nxt = (r_state == IDLE && start) ? 8'd0 :
                       (w_mis && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
    assign phase = r_state;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt = 8'd0;
        case (r_state)
            IDLE: w_state_nxt = start ? SET : IDLE;
            SET, DIS, RESET, HOLD, INVALID: begin
                w_state_nxt = w_last ? state_t'(r_state + 3'd1) : r_state;
                w_cnt_nxt = w_last ? 8'd0 : r_cnt + 8'd1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Drives and status are registered from the next state so they align with phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt <= 8'd0;
            {r_q_s1, r_q_s2, r_qn_s1, r_qn_s2} <= 4'b0;
            {s_out, r_out, en_out, busy, done, pass} <= 6'b0;
            err_count <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt <= w_cnt_nxt;
            {r_q_s1, r_q_s2} <= {q_in, r_q_s1};
            {r_qn_s1, r_qn_s2} <= {qn_in, r_qn_s1};
            en_out <= w_state_nxt inside {SET, RESET, HOLD, INVALID};
            s_out <= w_state_nxt inside {SET, INVALID};
            r_out <= w_state_nxt inside {DIS, RESET, INVALID};
            busy <= w_state_nxt inside {[SET:INVALID]};
            done <= w_state_nxt == DONE;
            err_count <= w_err_nxt;
            if (w_state_nxt == DONE)
                pass <= w_err_nxt == 8'd0;
        end
    end
endmodule

// File: tb/tb_sr_latch_exerciser.sv
// tb_sr_latch_exerciser: directed bench with a behavioural gated SR latch and selectable faults.
module tb_sr_latch_exerciser;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic       q_in, qn_in, s_out, r_out, en_out, busy, done, pass;
    logic [2:0] phase;
    logic [7:0] err_count;
    int         checks = 0, failures = 0;
    int         mode = 0;
    logic       m_q = 1'b0, m_inv = 1'b0;

`ifdef SR_INVALID_CHECK_EN
    localparam int INV_ERR = 1;
    localparam int QN_ERR = 3;
`else
    localparam int INV_ERR = 0;
    localparam int QN_ERR = 2;
`endif

    sr_latch_exerciser #(.HOLD_CYCLES(8), .SETTLE(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .q_in(q_in), .qn_in(qn_in),
        .s_out(s_out), .r_out(r_out), .en_out(en_out), .phase(phase),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // mode: 0 ideal, 1 Q stuck 0, 2 ignores En, 3 invalid gives (1,0), 4 Qn stuck 1
    always @(negedge clk) begin
        if (en_out || mode == 2) begin
            if (s_out && r_out) m_inv <= 1'b1;
            else if (s_out) begin m_q <= 1'b1; m_inv <= 1'b0; end
            else if (r_out) begin m_q <= 1'b0; m_inv <= 1'b0; end
        end
    end
    assign q_in  = (mode == 1) ? 1'b0 : m_inv ? (mode == 3) : m_q;
    assign qn_in = (mode == 4) ? 1'b1 : m_inv ? 1'b0 : !m_q;

    task automatic run(input int exp_err, input logic exp_pass, input string nm);
        int n = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        while (!done && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL %s_timeout: done=%b required 1", nm, done); end
        else begin
            checks++;
            if (err_count !== 8'(exp_err)) begin failures++; $display("FAIL %s_err: got %0d required %0d", nm, err_count, exp_err); end
            checks++;
            if (pass !== exp_pass) begin failures++; $display("FAIL %s_pass: got %b required %b", nm, pass, exp_pass); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({phase, s_out, r_out, en_out, busy, done, pass, err_count} !== 17'd0) begin
            failures++; $display("FAIL reset_outputs: got %h required 0", {phase, s_out, r_out, en_out, busy, done, pass, err_count});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (phase !== 3'd0 || busy !== 1'b0) begin failures++; $display("FAIL reset_stay_idle: phase=%0d busy=%b required 0 0", phase, busy); end
    endtask

    task automatic test_ideal_timing();
        logic [2:0] drv [5] = '{3'b110, 3'b001, 3'b101, 3'b100, 3'b111};
        mode = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (phase !== 3'(1 + i / 8) || busy !== 1'b1 || done !== 1'b0) begin
                failures++; $display("FAIL timing_phase cycle %0d: phase=%0d busy=%b done=%b required %0d 1 0", i, phase, busy, done, 1 + i / 8);
            end
            if (i % 8 == 0) begin
                checks++;
                if ({en_out, s_out, r_out} !== drv[i / 8]) begin
                    failures++; $display("FAIL drive_phase%0d: got %b required %b", 1 + i / 8, {en_out, s_out, r_out}, drv[i / 8]);
                end
            end
            @(negedge clk);
        end
        checks++;
        if ({phase, busy, done, pass, err_count} !== {3'd6, 3'b011, 8'd0}) begin
            failures++; $display("FAIL timing_done: phase=%0d busy=%b done=%b pass=%b err=%0d required 6 0 1 1 0", phase, busy, done, pass, err_count);
        end
        @(negedge clk);
        checks++;
        if (phase !== 3'd0 || done !== 1'b0) begin failures++; $display("FAIL timing_idle: phase=%0d done=%b required 0 0", phase, done); end
        repeat (5) @(negedge clk);
        checks++;
        if (pass !== 1'b1) begin failures++; $display("FAIL pass_hold: got %b required 1", pass); end
    endtask

    task automatic test_faults();
        mode = 1; run(2, 1'b0, "q_stuck");
        mode = 2; run(1, 1'b0, "ignore_en");
        mode = 3; run(INV_ERR, INV_ERR == 0, "invalid_10");
        mode = 0; run(0, 1'b1, "ideal");
    endtask

    task automatic test_back_to_back();
        int n = 0;
        mode = 1; run(2, 1'b0, "b2b_pre");
        mode = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        checks++;
        if (phase !== 3'd1 || err_count !== 8'd0) begin failures++; $display("FAIL err_clear: phase=%0d err=%0d required 1 0", phase, err_count); end
        while (!done && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL b2b_timeout: done=%b required 1", done); end
        @(negedge clk);
        checks++;
        if (phase !== 3'd0) begin failures++; $display("FAIL b2b_idle: phase=%0d required 0", phase); end
        @(negedge clk) start = 1'b0;
        checks++;
        if (phase !== 3'd1) begin failures++; $display("FAIL b2b_restart: phase=%0d required 1", phase); end
        n = 0;
        while (phase != 3'd0 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (phase !== 3'd0 || pass !== 1'b1) begin failures++; $display("FAIL b2b_second: phase=%0d pass=%b required 0 1", phase, pass); end
    endtask

    task automatic test_reset_abort();
        int n = 0;
        mode = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        while (phase != 3'd2 && n < 50) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({phase, s_out, r_out, en_out, busy, done, pass, err_count} !== 17'd0) begin
            failures++; $display("FAIL abort_outputs: got %h required 0", {phase, s_out, r_out, en_out, busy, done, pass, err_count});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (phase !== 3'd0 || done !== 1'b0 || pass !== 1'b0) begin
                failures++; $display("FAIL abort_idle: phase=%0d done=%b pass=%b required 0 0 0", phase, done, pass);
            end
        end
        run(0, 1'b1, "after_abort");
    endtask

    task automatic test_repeat_qn_stuck();
        mode = 4;
        for (int r = 0; r < 130; r++) run(QN_ERR, 1'b0, "qn_stuck");
    endtask

    initial begin
        test_reset();
        test_ideal_timing();
        test_faults();
        test_back_to_back();
        test_reset_abort();
        test_repeat_qn_stuck();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
